mips_imem_loader: RTL and testbench
===================================

# mips_imem_loader

Program loader that fills the MIPS instruction memory from a byte stream before the CPU runs. Bytes arrive over a valid/ready interface from a host link (UART receiver or testbench). A 16-bit word count header comes first, then big-endian instruction words. The block drives the instruction memory's write port and holds the CPU while loading, replacing the fixed power-on image.

## Interface
- `DEPTH`, 1024: instruction memory depth in 32-bit words; maximum loadable count.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `in_valid & in_ready`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address, always word-aligned: word index << 2.
- `mem_wdata`  out  32  assembled instruction word.
- `busy`  out  1  load in progress (HDR_HI through WRITE).
- `cpu_hold`  out  1  equals `busy`; keeps the CPU PC at 0.
- `done`  out  1  one-cycle pulse after the final word is written.
- `err`  out  1  header count exceeded `DEPTH`; sticky until the next accepted `start` or reset.

## Operation
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE: `in_ready` = 0. `start` leads to HDR_HI and clears `word_idx`, `byte_idx` and `err`.
- HDR_HI: `in_ready` = 1. On transfer, latch count[15:8] and go to HDR_LO.
- HDR_LO: `in_ready` = 1. On transfer, latch count[7:0], then:
  - count == 0 goes to DONE;
  - count > `DEPTH` goes to ERR;
  - otherwise go to DATA.
- DATA: `in_ready` = 1. Each transfer does `word <= {word[23:0], in_data}` and increments `byte_idx` (2-bit, wraps). The transfer taken with `byte_idx` == 3 goes to WRITE.
- WRITE: `in_ready` = 0, `mem_we` = 1, `mem_addr` = `word_idx` << 2, `mem_wdata` = `word`. Then increment `word_idx`. If the new `word_idx` == count, go to DONE, else go to DATA.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- ERR: `in_ready` = 0, `err` = 1. Stays in ERR until `start`.
- `start` in HDR_HI, HDR_LO, DATA or WRITE is ignored.
- `in_valid` low stalls the FSM indefinitely with no timeout. Partial bytes are retained.
- Bytes presented while `in_ready` = 0 are not consumed. The source must hold them.
- `mem_we` is low in every state except WRITE. `mem_addr` and `mem_wdata` hold their last values outside WRITE.

## Timing
- Reset (async assert, sync release):
  - state = IDLE;
  - all outputs 0, including `mem_addr` and `mem_wdata`;
  - count, `word_idx`, `byte_idx` and `word` = 0.
- `start` to first `in_ready`: 1 cycle.
- Last byte of a word accepted in cycle N: `mem_we` high in cycle N+1.
- Last write in cycle M: `done` high in cycle M+1 and `busy` low from cycle M+1. `busy` is low in DONE.
- Throughput is 5 cycles per word minimum (4 byte transfers plus 1 write cycle).
- Reset mid-load aborts immediately. Memory keeps the words already written. `cpu_hold` drops on reset assertion.

## Structure
- Shared package `mips_pkg` holds:
  - the loader state enum `imem_ld_state_t`;
  - the constant `IMEM_DEPTH = 1024`;
  - the header width constant `IMEM_CNT_W = 16`.
- One natural sub-module, `mips_word_packer`, owns:
  - the byte shift register and `byte_idx`;
  - a `word_full` flag raised on the 4th byte;
  - a clear input driven by `start`.
- The FSM, address counter and outputs stay in `mips_imem_loader`.

## Test plan
- **Two-word load.** `start`, then bytes 00 02 00 00 80 20 20 11 00 28 with `in_valid` held high.
  - Cycle 6: `mem_we`, `mem_addr` = 0x0, `mem_wdata` = 0x00008020.
  - Cycle 11: `mem_addr` = 0x4, `mem_wdata` = 0x20110028.
  - Cycle 12: `done` = 1. `busy` is low after.
- **Source stalls.** Same stream with `in_valid` toggling every other cycle. Identical writes and data, `mem_we` only one cycle per word, no byte lost or duplicated.
- **Zero count.** Header 00 00. Goes to DONE with no `mem_we`; `done` pulses 1 cycle after the second header byte.
- **Oversize count.** Header 04 01 (1025 > 1024). `err` = 1, `in_ready` stays 0, no writes. A later `start` clears `err` and a 1-word load succeeds at address 0x0.
- **Reset mid-load.** `rst_n` low after 2 of 3 words are written. All outputs 0 asynchronously. The next `start` with header 00 01 AA BB CC DD writes 0xAABBCCDD to address 0x0.
- **Start while busy.** `start` pulses during DATA. No effect: `word_idx` and byte assembly continue unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction-memory loader state encoding and sizing constants.
package mips_pkg;

  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned IMEM_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StWrite,
    StDone,
    StErr
  } imem_ld_state_t;

  // Word index to word-aligned byte address.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/mips_imem_loader_if.sv
// Loader bus: incoming byte stream (valid/ready) plus the instruction-memory write port.
interface mips_imem_loader_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // master: the loader (consumes bytes, drives memory writes)
  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  // slave: host link and instruction memory
  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/mips_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_full flags the 4th byte.
module mips_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  byte_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else if (clear) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else if (shift_en) begin
      word_q     <= {word_q[23:0], in_byte};
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  assign word      = word_q;
  assign byte_idx  = byte_idx_q;
  assign word_full = shift_en & (byte_idx_q == 2'd3);

endmodule

// File: rtl/mips_imem_loader.sv
// Streams a counted, big-endian program image into instruction memory, holding the CPU meanwhile.
module mips_imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  mips_imem_loader_if.master         bus,
  output logic                       busy,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned IdxW = $clog2(DEPTH + 1);

  imem_ld_state_t        state_q, state_d;
  logic [IMEM_CNT_W-1:0] count_q, count_d;
  logic [IdxW-1:0]       word_idx_q, word_idx_d;
  logic [31:0]           addr_q, wdata_q;

  logic                  rdy, we, xfer, start_ok, shift_en, word_full;
  logic [IMEM_CNT_W-1:0] hdr_cnt;
  logic [31:0]           word, wr_addr;
  logic [1:0]            byte_idx;

  assign xfer     = bus.in_valid & rdy;
  assign start_ok = start & (state_q inside {StIdle, StDone, StErr});
  assign hdr_cnt  = {count_q[IMEM_CNT_W-1:8], bus.in_data};
  assign wr_addr  = word_addr(32'(word_idx_q));

  mips_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .shift_en (shift_en),
    .in_byte  (bus.in_data),
    .word     (word),
    .byte_idx (byte_idx),
    .word_full(word_full)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    rdy        = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    shift_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d    = StHdrHi;
          word_idx_d = '0;
        end
      end
      StHdrHi: begin
        busy = 1'b1;
        rdy  = 1'b1;
        if (xfer) begin
          count_d[IMEM_CNT_W-1:8] = bus.in_data;
          state_d                 = StHdrLo;
        end
      end
      StHdrLo: begin
        busy = 1'b1;
        rdy  = 1'b1;
        if (xfer) begin
          count_d = hdr_cnt;
          if (hdr_cnt == '0)                state_d = StDone;
          else if (32'(hdr_cnt) > DEPTH)    state_d = StErr;
          else                              state_d = StData;
        end
      end
      StData: begin
        busy     = 1'b1;
        rdy      = 1'b1;
        shift_en = xfer;
        if (word_full) state_d = StWrite;
      end
      StWrite: begin
        busy       = 1'b1;
        we         = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
        if (32'(word_idx_q) + 32'd1 == 32'(count_q)) state_d = StDone;
        else                                         state_d = StData;
      end
      StDone: begin
        done = 1'b1;
        if (start_ok) begin
          state_d    = StHdrHi;
          word_idx_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StErr: begin
        err = 1'b1;
        if (start_ok) begin
          state_d    = StHdrHi;
          word_idx_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      if (we) begin
        addr_q  <= wr_addr;
        wdata_q <= word;
      end
    end
  end

  // Address/data are live during WRITE and hold the last written pair otherwise.
  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = we ? wr_addr : addr_q;
  assign bus.mem_wdata = we ? word : wdata_q;
  assign cpu_hold      = busy;

  logic unused_byte_idx;
  assign unused_byte_idx = ^byte_idx;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Scoreboard bench for mips_imem_loader: directed streams, monitor checks writes and done pulses.
module tb_mips_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, cpu_hold, done, err;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  exp_t e;

  mips_imem_loader_if bus ();

  mips_imem_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (bus.mem_we || done)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got we=%b done=%b addr=%h data=%h expected none",
                 bus.mem_we, done, bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_kind"}, 32'(done), 32'(e.is_done));
        if (!e.is_done) begin
          chk({e.name, "_addr"}, bus.mem_addr, e.addr);
          chk({e.name, "_data"}, bus.mem_wdata, e.data);
        end
        if (e.at >= 0) chk({e.name, "_cycle"}, cyc, e.at);
      end
    end
  end

  task automatic exp_w(input string n, input logic [31:0] a, input logic [31:0] d, input int at);
    exp_t x;
    x.is_done = 1'b0; x.addr = a; x.data = d; x.at = at; x.name = n;
    sb.push_back(x);
  endtask

  task automatic exp_d(input string n, input int at);
    exp_t x;
    x.is_done = 1'b1; x.addr = '0; x.data = '0; x.at = at; x.name = n;
    sb.push_back(x);
  endtask

  task automatic do_start(output int c0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  // Drive bytes in order; a byte advances only on a sampled valid&ready transfer.
  task automatic send(input bq_t b, input bit stall, input string n);
    int i = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (i < b.size() && guard < 200) begin
      bus.in_valid = stall ? ph : 1'b1;
      bus.in_data  = b[i];
      ph = ~ph;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (i < b.size()) begin
      checks++;
      $display("FAIL %s_send_timeout: got %0d bytes expected %0d", n, i, b.size());
    end
  endtask

  task automatic drain(input string n);
    int g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk({n, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int   c0;
    bq_t  q;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #23;
    chk("rst_flags", {26'd0, bus.in_ready, bus.mem_we, busy, cpu_hold, done, err}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.in_ready), 32'd0);

    // Two-word load at full rate, cycle-exact.
    do_start(c0);
    chk("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
    chk("t1_busy", {30'd0, busy, cpu_hold}, 32'd3);
    exp_w("t1_w0", 32'h0, 32'h0000_8020, c0 + 6);
    exp_w("t1_w1", 32'h4, 32'h2011_0028, c0 + 11);
    exp_d("t1_done", c0 + 12);
    q = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h80, 8'h20, 8'h20, 8'h11, 8'h00, 8'h28};
    send(q, 1'b0, "t1");
    drain("t1");
    chk("t1_busy_after", {30'd0, busy, cpu_hold}, 32'd0);
    chk("t1_hold_addr", bus.mem_addr, 32'h4);
    chk("t1_hold_data", bus.mem_wdata, 32'h2011_0028);

    // Same stream with the source stalling every other cycle.
    do_start(c0);
    exp_w("t2_w0", 32'h0, 32'h0000_8020, -1);
    exp_w("t2_w1", 32'h4, 32'h2011_0028, -1);
    exp_d("t2_done", -1);
    send(q, 1'b1, "t2");
    drain("t2");

    // Zero count: done two cycles after start, no writes.
    do_start(c0);
    exp_d("t3_done", c0 + 2);
    q = '{8'h00, 8'h00};
    send(q, 1'b0, "t3");
    drain("t3");

    // Oversize count: sticky err, bytes refused, then recovery.
    do_start(c0);
    q = '{8'h04, 8'h01};
    send(q, 1'b0, "t4");
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_ready_low", {30'd0, bus.in_ready, err}, 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    do_start(c0);
    chk("t4_err_cleared", 32'(err), 32'd0);
    exp_w("t4_w0", 32'h0, 32'hDEAD_BEEF, c0 + 6);
    exp_d("t4_done", c0 + 7);
    q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(q, 1'b0, "t4");
    drain("t4");

    // Reset after two of three words.
    do_start(c0);
    exp_w("t5_w0", 32'h0, 32'h1111_2222, -1);
    exp_w("t5_w1", 32'h4, 32'h3333_4444, -1);
    q = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    send(q, 1'b0, "t5");
    @(posedge clk); #1;
    chk("t5_busy_mid", 32'(busy), 32'd1);
    chk("t5_two_written", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_flags", {26'd0, bus.in_ready, bus.mem_we, busy, cpu_hold, done, err}, 32'd0);
    chk("t5_rst_addr", bus.mem_addr, 32'd0);
    chk("t5_rst_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(c0);
    exp_w("t5_reload", 32'h0, 32'hAABB_CCDD, c0 + 6);
    exp_d("t5_done", c0 + 7);
    q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(q, 1'b0, "t5");
    drain("t5");

    // Start pulse during DATA must be ignored.
    do_start(c0);
    exp_w("t6_w0", 32'h0, 32'h0000_8020, -1);
    exp_w("t6_w1", 32'h4, 32'h2011_0028, -1);
    exp_d("t6_done", -1);
    q = '{8'h00, 8'h02, 8'h00, 8'h00};
    send(q, 1'b0, "t6");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_still_busy", 32'(busy), 32'd1);
    q = '{8'h80, 8'h20, 8'h20, 8'h11, 8'h00, 8'h28};
    send(q, 1'b0, "t6");
    drain("t6");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
